demux_tdm_1a4: RTL and testbench

DEMUX_TDM_1A4 -- requirements
Module: demux_tdm_1a4

---
 rtl/demux_tdm_1a4.sv | 126 ++++++++++++
 tb/tb_demux_tdm_1a4.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_tdm_1a4.sv
// Four-channel TDM demultiplexer: hunts for a frame-start sync, collects four
// words into shadow registers and publishes a complete frame in one edge.
module demux_tdm_1a4 #(
  parameter int ANCHO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [ANCHO-1:0] in_dato,
  output logic [ANCHO-1:0] out0,
  output logic [ANCHO-1:0] out1,
  output logic [ANCHO-1:0] out2,
  output logic [ANCHO-1:0] out3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [1:0]       canal,
  output logic             enganchado
);

  typedef enum logic {BUSCAR, RECIBIR} estado_t;

  estado_t          state, state_nx;
  logic [1:0]       cnt, cnt_nx;
  logic [ANCHO-1:0] sh0, sh1, sh2;
  logic [ANCHO-1:0] sh0_nx, sh1_nx, sh2_nx;
  logic [ANCHO-1:0] out0_nx, out1_nx, out2_nx, out3_nx;
  logic             frame_valid_nx, sync_err_nx;

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    // NOTE: the shadow words are reset too, so a frame can never be built
    // from stale data left behind by an earlier lock.
    if (rst) begin
      state       <= BUSCAR;
      cnt         <= '0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sh0         <= sh0_nx;
      sh1         <= sh1_nx;
      sh2         <= sh2_nx;
      out0        <= out0_nx;
      out1        <= out1_nx;
      out2        <= out2_nx;
      out3        <= out3_nx;
      frame_valid <= frame_valid_nx;
      sync_err    <= sync_err_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nx       = state;
    cnt_nx         = cnt;
    sh0_nx         = sh0;
    sh1_nx         = sh1;
    sh2_nx         = sh2;
    out0_nx        = out0;
    out1_nx        = out1;
    out2_nx        = out2;
    out3_nx        = out3;
    frame_valid_nx = 1'b0;
    sync_err_nx    = 1'b0;

    if (in_valid) begin
      unique case (state)
        BUSCAR: begin
          if (in_sync) begin
            sh0_nx   = in_dato;
            cnt_nx   = 2'd1;
            state_nx = RECIBIR;
          end
        end
        RECIBIR: begin
          if (in_sync) begin
            // A sync anywhere but channel 0 aborts the partial frame and
            // restarts collection with this word.
            sync_err_nx = (cnt != 2'd0);
            sh0_nx      = in_dato;
            cnt_nx      = 2'd1;
          end else begin
            case (cnt)
              2'd0: begin
                sync_err_nx = 1'b1;
                cnt_nx      = 2'd0;
                state_nx    = BUSCAR;
              end
              2'd1: begin
                sh1_nx = in_dato;
                cnt_nx = 2'd2;
              end
              2'd2: begin
                sh2_nx = in_dato;
                cnt_nx = 2'd3;
              end
              2'd3: begin
                out0_nx        = sh0;
                out1_nx        = sh1;
                out2_nx        = sh2;
                out3_nx        = in_dato;
                cnt_nx         = 2'd0;
                frame_valid_nx = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign enganchado = (state == RECIBIR);
  assign canal      = enganchado ? cnt : 2'd0;

endmodule

// File: tb/tb_demux_tdm_1a4.sv
// Self-checking bench for demux_tdm_1a4: a behavioural model pushes expected
// post-edge outputs to a queue, popped and compared one cycle later.
module tb_demux_tdm_1a4;

  localparam int ANCHO = 16;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_sync;
  logic [ANCHO-1:0] in_dato;
  logic [ANCHO-1:0] out0, out1, out2, out3;
  logic             frame_valid, sync_err, enganchado;
  logic [1:0]       canal;

  demux_tdm_1a4 #(.ANCHO(ANCHO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
    .in_dato(in_dato), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .frame_valid(frame_valid), .sync_err(sync_err), .canal(canal),
    .enganchado(enganchado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic        se;
    logic [1:0]  canal;
    logic        eng;
    logic [63:0] outs;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int fv_seen = 0;
  int se_seen = 0;

  // Reference model state
  logic             m_lock;
  logic [1:0]       m_cnt;
  logic [ANCHO-1:0] m_sh [3];
  logic [ANCHO-1:0] m_out [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic s, input logic [ANCHO-1:0] d);
    exp_t e;
    e.fv = 1'b0;
    e.se = 1'b0;
    if (r) begin
      m_lock = 1'b0;
      m_cnt  = 2'd0;
      for (int i = 0; i < 3; i++) m_sh[i] = '0;
      for (int i = 0; i < 4; i++) m_out[i] = '0;
    end else if (v) begin
      if (!m_lock) begin
        if (s) begin m_sh[0] = d; m_cnt = 2'd1; m_lock = 1'b1; end
      end else if (s) begin
        e.se = (m_cnt != 2'd0);
        m_sh[0] = d;
        m_cnt = 2'd1;
      end else if (m_cnt == 2'd0) begin
        e.se = 1'b1;
        m_lock = 1'b0;
      end else if (m_cnt == 2'd3) begin
        m_out[0] = m_sh[0]; m_out[1] = m_sh[1]; m_out[2] = m_sh[2]; m_out[3] = d;
        m_cnt = 2'd0;
        e.fv = 1'b1;
      end else begin
        m_sh[m_cnt] = d;
        m_cnt = m_cnt + 2'd1;
      end
    end
    e.canal = m_lock ? m_cnt : 2'd0;
    e.eng   = m_lock;
    e.outs  = {m_out[0], m_out[1], m_out[2], m_out[3]};
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [ANCHO-1:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_sync = s; in_dato = d;
    model(r, v, s, d);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("frame_valid", frame_valid, e.fv);
      check("sync_err", sync_err, e.se);
      check("canal", canal, e.canal);
      check("enganchado", enganchado, e.eng);
      check("outs", {out0, out1, out2, out3}, e.outs);
      check("fv_se_exclusive", frame_valid & sync_err, 1'b0);
    end
    if (frame_valid) fv_seen++;
    if (sync_err) se_seen++;
  endtask

  task automatic word(input logic s, input logic [ANCHO-1:0] d);
    step(1'b0, 1'b1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'hDEAD);
  endtask

  task automatic frame(input logic [ANCHO-1:0] a, b, c, d, input int gap);
    word(1'b1, a); idle(gap);
    word(1'b0, b); idle(gap);
    word(1'b0, c); idle(gap);
    word(1'b0, d);
  endtask

  task automatic clear_counts();
    fv_seen = 0;
    se_seen = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_dato = '0;
    m_lock = 1'b0; m_cnt = 2'd0;

    // Reset, including priority over a valid sync word
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF);
    check("reset_eng", enganchado, 1'b0);
    check("reset_outs", {out0, out1, out2, out3}, 64'd0);

    // Basic frame
    clear_counts();
    frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0);
    check("basic_outs", {out0, out1, out2, out3}, 64'h1111_2222_3333_4444);
    check("basic_fv_now", frame_valid, 1'b1);
    check("basic_canal", canal, 2'd0);
    idle(2);
    check("basic_fv_count", fv_seen, 1);

    // Same frame with 3-cycle gaps
    clear_counts();
    frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 3);
    idle(2);
    check("gap_fv_count", fv_seen, 1);
    check("gap_outs", {out0, out1, out2, out3}, 64'h1111_2222_3333_4444);

    // Back-to-back frames
    clear_counts();
    frame(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 0);
    check("b2b_first_outs", {out0, out1, out2, out3}, 64'h00A0_00A1_00A2_00A3);
    frame(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3, 0);
    check("b2b_fv_count", fv_seen, 2);
    check("b2b_se_count", se_seen, 0);
    check("b2b_outs", {out0, out1, out2, out3}, 64'h00B0_00B1_00B2_00B3);

    // Early sync aborts the partial frame
    clear_counts();
    word(1'b1, 16'h0001);
    word(1'b0, 16'h0002);
    word(1'b1, 16'h0010);
    check("early_se", sync_err, 1'b1);
    check("early_eng", enganchado, 1'b1);
    word(1'b0, 16'h0020);
    word(1'b0, 16'h0030);
    word(1'b0, 16'h0040);
    check("early_outs", {out0, out1, out2, out3}, 64'h0010_0020_0030_0040);
    check("early_se_count", se_seen, 1);

    // Missing sync drops lock; further non-sync words ignored
    clear_counts();
    word(1'b0, 16'h5555);
    check("miss_se", sync_err, 1'b1);
    check("miss_eng", enganchado, 1'b0);
    word(1'b0, 16'h6666);
    word(1'b0, 16'h7777);
    idle(1);
    word(1'b0, 16'h8888);
    check("miss_se_count", se_seen, 1);
    check("miss_outs_held", {out0, out1, out2, out3}, 64'h0010_0020_0030_0040);
    frame(16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3, 1);
    check("relock_outs", {out0, out1, out2, out3}, 64'hC0C0_C1C1_C2C2_C3C3);

    // Reset mid-frame
    clear_counts();
    word(1'b1, 16'h0101);
    word(1'b0, 16'h0202);
    step(1'b1, 1'b0, 1'b0, '0);
    check("midrst_outs", {out0, out1, out2, out3}, 64'd0);
    check("midrst_eng", enganchado, 1'b0);
    word(1'b0, 16'h0303);
    word(1'b0, 16'h0404);
    idle(2);
    check("midrst_fv_count", fv_seen, 0);
    check("midrst_se_count", se_seen, 0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ANCHO'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
